// File: rtl/seq_pattern_pkg.sv
// Shared types and widths for the serial pattern transmitter.
// The state enum is shared so the top and its bench agree on the FSM encoding.
package seq_pattern_pkg;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down counter with a zero flag.
// A decrement request at zero is ignored, so the count never wraps below zero.
module bit_down_counter
  import seq_pattern_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [LEN_W-1:0] load_val,
  output logic [LEN_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serialises data_in[len_in:0] MSB-first onto x, one bit per cycle, followed by one idle GAP cycle.
// x, x_valid and done are registered; the counter holds the index of the bit currently on x.
module seq_pattern_tx
  import seq_pattern_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              x,
  output logic              x_valid,
  output logic              done
);

  // Handshake: a frame transfers on a rising edge where valid_in and ready_out are both 1.
  // ready_out is high only in IDLE with reset low; inputs are ignored at all other times.

  state_t              state_q;
  state_t              state_d;
  logic [DATA_W-1:0]   sr_q;
  logic [LEN_W-1:0]    cnt;
  logic [LEN_W-1:0]    cnt_m1;
  logic                cnt_zero;
  logic                accept;
  logic                load;
  logic                dec;
  logic                x_d;
  logic                x_valid_d;
  logic                done_d;

  assign ready_out = (state_q == IDLE) && !reset;
  assign accept    = valid_in && ready_out;
  assign cnt_m1    = cnt - 1'b1;

  bit_down_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .dec      (dec),
    .load_val (len_in),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    done_d    = 1'b0;
    load      = 1'b0;
    dec       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // First bit comes straight from the inputs so it is on x the cycle after acceptance.
          load      = 1'b1;
          state_d   = SHIFT;
          x_d       = data_in[len_in];
          x_valid_d = 1'b1;
          done_d    = (len_in == '0);
        end
      end
      SHIFT: begin
        if (cnt_zero) begin
          state_d = GAP;
        end else begin
          dec       = 1'b1;
          x_d       = sr_q[cnt_m1];
          x_valid_d = 1'b1;
          done_d    = (cnt_m1 == '0);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      x       <= x_d;
      x_valid <= x_valid_d;
      done    <= done_d;
      if (load) begin
        sr_q <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: a frame-level model predicts each bit and its cycle,
// and a negedge monitor pops and compares whatever the DUT puts on x.
module tb_seq_pattern_tx;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic [2:0] len_in;
  logic       valid_in;
  logic       ready_out;
  logic       x;
  logic       x_valid;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int free_edge = 0;
  int frames = 0;

  // Expected item: {cycle tag[31:0], x, done}
  logic [33:0] exp_q[$];

  logic [3:0] hist = 4'b0000;
  logic       last_y = 1'b0;

  seq_pattern_tx dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .len_in    (len_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .x         (x),
    .x_valid   (x_valid),
    .done      (done)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endtask

  // Drive one cycle of inputs and update the frame-level model for the coming edge.
  task automatic drive_cycle(input logic v, input logic [7:0] d, input logic [2:0] l, input logic r);
    int e;
    int n;
    int idx;
    logic exp_ready;
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    len_in   = l;
    reset    = r;
    e = cyc + 1;
    #1;
    exp_ready = !r && (e >= free_edge);
    chk("ready_out", {31'd0, ready_out}, {31'd0, exp_ready});
    if (r) begin
      while (exp_q.size() > 0 && int'(exp_q[$][33:2]) >= e) void'(exp_q.pop_back());
      free_edge = e + 1;
    end else if (v && e >= free_edge) begin
      n = int'(l) + 1;
      for (int j = 0; j < n; j++) begin
        idx = int'(l) - j;
        exp_q.push_back({32'(e + j), d[idx], (j == n - 1)});
      end
      free_edge = e + n + 2;
      frames++;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive_cycle(1'b0, 8'($urandom), 3'($urandom), 1'b0);
  endtask

  // Monitor: pops the expected bit whose tag matches the current cycle.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (x_valid) begin
        if (exp_q.size() > 0 && int'(exp_q[0][33:2]) == cyc) begin
          chk("x_bit", {31'd0, x}, {31'd0, exp_q[0][1]});
          chk("done", {31'd0, done}, {31'd0, exp_q[0][0]});
          void'(exp_q.pop_front());
        end else begin
          chk("unexpected_x_valid", 32'd1, 32'd0);
        end
        hist = {hist[2:0], x};
        if (done) last_y = (hist == 4'b0101);
      end else begin
        chk("idle_x_done", {30'd0, x, done}, 32'd0);
        if (exp_q.size() > 0 && int'(exp_q[0][33:2]) == cyc) begin
          chk("missing_bit", 32'd0, 32'd1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    len_in   = 3'd0;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'hff, 3'd7, 1'b1);
    idle(2);

    // 8-bit frame 1011_0101
    drive_cycle(1'b1, 8'b1011_0101, 3'd7, 1'b0);
    idle(12);

    // 3-bit frame with random upper bits
    drive_cycle(1'b1, {5'($urandom), 3'b101}, 3'd2, 1'b0);
    idle(6);

    // valid_in held high with fresh data every cycle
    for (int i = 0; i < 60; i++) drive_cycle(1'b1, 8'($urandom), 3'($urandom), 1'b0);
    idle(12);

    // Reset during the 4th bit of an 8-bit frame
    drive_cycle(1'b1, 8'b1111_1111, 3'd7, 1'b0);
    idle(3);
    drive_cycle(1'b1, 8'($urandom), 3'd7, 1'b1);
    idle(12);

    // Single-bit frame
    drive_cycle(1'b1, 8'b0000_0001, 3'd0, 1'b0);
    idle(4);

    // Loopback pattern 0101 into the detector model
    last_y = 1'b0;
    drive_cycle(1'b1, 8'b1010_0101, 3'd3, 1'b0);
    idle(7);
    chk("loopback_y", {31'd0, last_y}, 32'd1);

    // Random traffic with sporadic resets
    for (int i = 0; i < 400; i++)
      drive_cycle(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom),
                  ($urandom_range(0, 39) == 0));
    idle(15);

    chk("queue_drained", exp_q.size(), 32'd0);
    chk("frames_seen", {31'd0, (frames > 10)}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high; sampled only on rising clk.
REQ-003 SHALL have port: data_in  input  8  parallel pattern; transmitted bits are data_in[len_in:0].
REQ-004 SHALL have port: len_in  input  3  frame length minus one (000 = 1 bit, 111 = 8 bits).
REQ-005 SHALL have port: valid_in  input  1  producer offers data_in/len_in this cycle.
REQ-006 SHALL have port: ready_out  output  1  block can accept a frame this cycle.
REQ-007 SHALL have port: x  output  1  serial bit stream, driven to the sequence detector's x input.
REQ-008 SHALL have port: x_valid  output  1  x carries a frame bit this cycle.
REQ-009 SHALL have port: done  output  1  one-cycle pulse coincident with the last bit of a frame.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, GAP.
REQ-011 SHALL drive ready_out = 1 only when state is IDLE and reset is 0.
REQ-012 SHALL accept a frame on a rising edge where valid_in = 1 and ready_out = 1, latching data_in and len_in.
REQ-013 SHALL ignore data_in, len_in and valid_in whenever ready_out = 0; latched values are not disturbed.
REQ-014 SHALL, on acceptance at edge E, enter SHIFT and present bit data_in[len_in] on x with x_valid = 1 in the cycle after E.
REQ-015 SHALL transmit MSB-first: bits data_in[len_in] down to data_in[0], one bit per cycle, on n = len_in+1 consecutive cycles.
REQ-016 SHALL register x, x_valid and done; none are combinational from inputs.
REQ-017 SHALL assert done = 1 only in the cycle the bit data_in[0] is on x.
REQ-018 SHALL leave SHIFT for GAP after the last bit; in GAP x = 0, x_valid = 0, done = 0 for exactly one cycle.
REQ-019 SHALL return from GAP to IDLE on the next edge.
REQ-020 SHALL give minimum spacing between consecutive acceptance edges of n+2 cycles.
REQ-021 SHALL drive x = 0 whenever x_valid = 0.
REQ-022 SHALL hold a bit counter of 3 bits, loaded with len_in on acceptance and decremented per transmitted bit; it SHALL NOT wrap below 0.
REQ-023 SHALL, for len_in = 000, transmit one bit with x_valid and done both high in the same single cycle.

Reset
REQ-024 SHALL, on any edge with reset = 1, force state IDLE, x = 0, x_valid = 0, done = 0, counter = 0, shift register = 0.
REQ-025 SHALL abort an in-progress frame on reset with no done pulse; the aborted frame is not resumed.
REQ-026 SHALL give reset priority over a simultaneous valid_in; no frame is accepted on that edge.
REQ-027 SHALL have ready_out = 1 in the first cycle after reset deasserts.

Structure
REQ-028 SHALL place the state enum (IDLE, SHIFT, GAP), DATA_W = 8 and LEN_W = 3 in shared package seq_pattern_pkg.
REQ-029 SHALL be a single module; an optional sub-module bit_down_counter (LEN_W-bit loadable down counter with zero flag) is permitted.
REQ-030 SHALL have a 120-400 line RTL implementation.

Verification
REQ-031 SHALL verify: data_in = 8'b1011_0101, len_in = 7, single valid pulse -> x = 1,0,1,1,0,1,0,1 on 8 x_valid cycles, done on 8th, GAP, then ready_out = 1.
REQ-032 SHALL verify: data_in = 8'bxxxx_x101, len_in = 2 -> x = 1,0,1 on 3 cycles; upper data bits never appear on x.
REQ-033 SHALL verify: valid_in held high continuously with new data each cycle -> only frames offered while ready_out = 1 are sent, spacing n+2 cycles, no bits lost or duplicated.
REQ-034 SHALL verify: reset = 1 during the 4th bit of an 8-bit frame -> next cycle x = 0, x_valid = 0, done never pulses, ready_out = 1 after reset drops.
REQ-035 SHALL verify: len_in = 0, data_in[0] = 1 -> one cycle with x = 1, x_valid = 1, done = 1, followed by one GAP cycle.
REQ-036 SHALL verify, as loopback: x driven into the team's sequence detector with pattern 0101 sent -> detector y asserts on the final bit.
